// File: rtl/pll_sequencer.sv
// rPLL sequencer: drives the PLL resets, qualifies LOCK into a clean clk_ready,
// applies divider reconfiguration and retries a bounded number of times on failure.
module pll_sequencer #(
   parameter int          RESET_CYCLES        = 16,
   parameter int          LOCK_STABLE_CYCLES  = 1024,
   parameter int          LOCK_TIMEOUT_CYCLES = 65536,
   parameter int          LOSS_FILTER         = 4,
   parameter int          MAX_RETRIES         = 3,
   parameter logic [5:0]  DEF_IDSEL           = 6'd57,
   parameter logic [5:0]  DEF_FBDSEL          = 6'd12,
   parameter logic [5:0]  DEF_ODSEL           = 6'd62
) (
   input  logic       clkin,
   input  logic       reset_n,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic       pll_reset_p,
   output logic [5:0] pll_idsel,
   output logic [5:0] pll_fbdsel,
   output logic [5:0] pll_odsel,
   input  logic       cfg_req,
   input  logic [5:0] cfg_idsel,
   input  logic [5:0] cfg_fbdsel,
   input  logic [5:0] cfg_odsel,
   output logic       cfg_ack,
   output logic       clk_ready,
   output logic       lock_lost,
   output logic       fail,
   output logic [1:0] retry_count,
   output logic [2:0] dbg_state
);

   localparam int MAX_A = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_B = (LOCK_TIMEOUT_CYCLES > LOSS_FILTER) ? LOCK_TIMEOUT_CYCLES : LOSS_FILTER;
   localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_P + 1);

   localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] LOSS_LAST    = CW'(LOSS_FILTER - 1);
   localparam logic [1:0]    MAX_R        = 2'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_READY     = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sync1_q, lock_s_q;
   logic [5:0]    idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
   logic [1:0]    retry_q, retry_d;
   logic          ack_q, ack_d, lost_q, lost_d;
   logic          ready_q, ready_d, fail_q, fail_d, pll_reset_q, pll_reset_d;
   logic          retry_now, accept;

   // Handshake: the requester holds cfg_req and cfg_* stable until it sees the
   // one-cycle cfg_ack; requests are only taken in S_READY or S_FAIL, never queued.
   assign accept = cfg_req && ((state_q == S_READY) || (state_q == S_FAIL));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      idsel_d   = idsel_q;
      fbdsel_d  = fbdsel_q;
      odsel_d   = odsel_q;
      retry_d   = retry_q;
      ack_d     = 1'b0;
      lost_d    = 1'b0;
      retry_now = 1'b0;
      case (state_q)
         S_RESET: begin
            if (cnt_q == RESET_LAST) state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (lock_s_q)                   state_d = S_STABLE;
            else if (cnt_q == TIMEOUT_LAST) retry_now = 1'b1;
         end
         S_STABLE: begin
            if (!lock_s_q) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_READY;
               retry_d = 2'd0;
            end
         end
         S_READY: begin
            // In READY the counter measures the current run of lock_s low cycles.
            if (lock_s_q) begin
               cnt_d = '0;
            end else if (cnt_q == LOSS_LAST) begin
               lost_d    = 1'b1;
               retry_now = 1'b1;
            end
         end
         S_FAIL: begin
            cnt_d = cnt_q;
         end
         default: state_d = S_RESET;
      endcase

      if (retry_now) begin
         if (retry_q < MAX_R) begin
            retry_d = retry_q + 2'd1;
            state_d = S_RESET;
         end else begin
            state_d = S_FAIL;
         end
      end

      // A reconfig overrides a simultaneous lock-loss retry but keeps the lost pulse.
      if (accept) begin
         idsel_d  = cfg_idsel;
         fbdsel_d = cfg_fbdsel;
         odsel_d  = cfg_odsel;
         ack_d    = 1'b1;
         retry_d  = 2'd0;
         state_d  = S_RESET;
      end

      if (state_d != state_q) cnt_d = '0;

      pll_reset_d = (state_d == S_RESET) || (state_d == S_FAIL);
      ready_d     = (state_d == S_READY);
      fail_d      = (state_d == S_FAIL);
   end

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_RESET;
         cnt_q       <= '0;
         sync1_q     <= 1'b0;
         lock_s_q    <= 1'b0;
         idsel_q     <= DEF_IDSEL;
         fbdsel_q    <= DEF_FBDSEL;
         odsel_q     <= DEF_ODSEL;
         retry_q     <= 2'd0;
         ack_q       <= 1'b0;
         lost_q      <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
         pll_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sync1_q     <= pll_lock;
         lock_s_q    <= sync1_q;
         idsel_q     <= idsel_d;
         fbdsel_q    <= fbdsel_d;
         odsel_q     <= odsel_d;
         retry_q     <= retry_d;
         ack_q       <= ack_d;
         lost_q      <= lost_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
         pll_reset_q <= pll_reset_d;
      end
   end

   assign pll_reset   = pll_reset_q;
   assign pll_reset_p = pll_reset_q;
   assign pll_idsel   = idsel_q;
   assign pll_fbdsel  = fbdsel_q;
   assign pll_odsel   = odsel_q;
   assign cfg_ack     = ack_q;
   assign clk_ready   = ready_q;
   assign lock_lost   = lost_q;
   assign fail        = fail_q;
   assign retry_count = retry_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// Directed bench for pll_sequencer with shortened lock/timeout parameters:
// a phase table walks the whole sequence, hand sequences cover reset and reconfig races.
module tb_pll_sequencer;

   localparam int RC = 16;
   localparam int LS = 32;
   localparam int LT = 100;
   localparam int LF = 4;
   localparam int MR = 3;

   localparam logic [2:0] RS = 3'd0, WT = 3'd1, ST = 3'd2, RD = 3'd3, FL = 3'd4;
   localparam logic [17:0] D = {6'd57, 6'd12, 6'd62};
   localparam logic [17:0] A = {6'd58, 6'd20, 6'd60};
   localparam logic [17:0] B = {6'd10, 6'd11, 6'd12};

   logic       clkin = 1'b0;
   logic       reset_n = 1'b0;
   logic       pll_lock = 1'b0;
   logic       cfg_req = 1'b0;
   logic [5:0] cfg_idsel = 6'd0, cfg_fbdsel = 6'd0, cfg_odsel = 6'd0;
   logic       pll_reset, pll_reset_p, cfg_ack, clk_ready, lock_lost, fail;
   logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
   logic [1:0] retry_count;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int ack_seen = 0;
   int lost_seen = 0;

   pll_sequencer #(
      .RESET_CYCLES(RC), .LOCK_STABLE_CYCLES(LS), .LOCK_TIMEOUT_CYCLES(LT),
      .LOSS_FILTER(LF), .MAX_RETRIES(MR),
      .DEF_IDSEL(6'd57), .DEF_FBDSEL(6'd12), .DEF_ODSEL(6'd62)
   ) dut (
      .clkin(clkin), .reset_n(reset_n), .pll_lock(pll_lock),
      .pll_reset(pll_reset), .pll_reset_p(pll_reset_p),
      .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
      .cfg_req(cfg_req), .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
      .cfg_ack(cfg_ack), .clk_ready(clk_ready), .lock_lost(lock_lost), .fail(fail),
      .retry_count(retry_count), .dbg_state(dbg_state)
   );

   always #5 clkin = ~clkin;

   // Pulse counters: at a check made just after an edge they cover earlier cycles only.
   always @(negedge clkin) begin
      if (cfg_ack === 1'b1)   ack_seen++;
      if (lock_lost === 1'b1) lost_seen++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          adv;
      logic [2:0]  st;
      logic        rst, rdy, fl, ack, lost;
      logic [1:0]  rc;
      int          ackc, lostc;
      logic [17:0] esel;
      logic        lock, req;
      logic [17:0] csel;
   } vec_t;

   function automatic vec_t v(input int adv, input logic [2:0] st, input logic rst, input logic rdy,
                              input logic fl, input logic ack, input logic lost, input logic [1:0] rc,
                              input int ackc, input int lostc, input logic [17:0] esel,
                              input logic lock, input logic req, input logic [17:0] csel);
      vec_t r;
      r.adv = adv; r.st = st; r.rst = rst; r.rdy = rdy; r.fl = fl; r.ack = ack; r.lost = lost;
      r.rc = rc; r.ackc = ackc; r.lostc = lostc; r.esel = esel;
      r.lock = lock; r.req = req; r.csel = csel;
      return r;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clkin);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input vec_t e);
      chk({tag, " state"},       {29'd0, dbg_state}, {29'd0, e.st});
      chk({tag, " pll_reset"},   {31'd0, pll_reset}, {31'd0, e.rst});
      chk({tag, " pll_reset_p"}, {31'd0, pll_reset_p}, {31'd0, e.rst});
      chk({tag, " clk_ready"},   {31'd0, clk_ready}, {31'd0, e.rdy});
      chk({tag, " fail"},        {31'd0, fail}, {31'd0, e.fl});
      chk({tag, " cfg_ack"},     {31'd0, cfg_ack}, {31'd0, e.ack});
      chk({tag, " lock_lost"},   {31'd0, lock_lost}, {31'd0, e.lost});
      chk({tag, " retry_count"}, {30'd0, retry_count}, {30'd0, e.rc});
      chk({tag, " ack_pulses"},  ack_seen, e.ackc);
      chk({tag, " lost_pulses"}, lost_seen, e.lostc);
      chk({tag, " selects"},     {14'd0, pll_idsel, pll_fbdsel, pll_odsel}, {14'd0, e.esel});
   endtask

   vec_t tbl[$];

   initial begin
      int n;
      // cold start (lock at cycle 40), 3-cycle glitch, 6-cycle loss, relock
      tbl.push_back(v( 0, RS, 1, 0, 0, 0, 0, 0, 0, 0, D, 0, 0, D));
      tbl.push_back(v(15, RS, 1, 0, 0, 0, 0, 0, 0, 0, D, 0, 0, D));
      tbl.push_back(v( 1, WT, 0, 0, 0, 0, 0, 0, 0, 0, D, 0, 0, D));
      tbl.push_back(v(24, WT, 0, 0, 0, 0, 0, 0, 0, 0, D, 1, 0, D));
      tbl.push_back(v( 2, WT, 0, 0, 0, 0, 0, 0, 0, 0, D, 1, 0, D));
      tbl.push_back(v( 1, ST, 0, 0, 0, 0, 0, 0, 0, 0, D, 1, 0, D));
      tbl.push_back(v(31, ST, 0, 0, 0, 0, 0, 0, 0, 0, D, 1, 0, D));
      tbl.push_back(v( 1, RD, 0, 1, 0, 0, 0, 0, 0, 0, D, 0, 0, D));
      tbl.push_back(v( 3, RD, 0, 1, 0, 0, 0, 0, 0, 0, D, 1, 0, D));
      tbl.push_back(v( 4, RD, 0, 1, 0, 0, 0, 0, 0, 0, D, 0, 0, D));
      tbl.push_back(v( 5, RD, 0, 1, 0, 0, 0, 0, 0, 0, D, 0, 0, D));
      tbl.push_back(v( 1, RS, 1, 0, 0, 0, 1, 1, 0, 0, D, 1, 0, D));
      tbl.push_back(v( 1, RS, 1, 0, 0, 0, 0, 1, 0, 1, D, 1, 0, D));
      tbl.push_back(v(14, RS, 1, 0, 0, 0, 0, 1, 0, 1, D, 1, 0, D));
      tbl.push_back(v( 1, WT, 0, 0, 0, 0, 0, 1, 0, 1, D, 1, 0, D));
      tbl.push_back(v( 1, ST, 0, 0, 0, 0, 0, 1, 0, 1, D, 1, 0, D));
      tbl.push_back(v(31, ST, 0, 0, 0, 0, 0, 1, 0, 1, D, 1, 0, D));
      // reconfig from READY, then a one-cycle glitch in STABLE
      tbl.push_back(v( 1, RD, 0, 1, 0, 0, 0, 0, 0, 1, D, 1, 1, A));
      tbl.push_back(v( 1, RS, 1, 0, 0, 1, 0, 0, 0, 1, A, 1, 0, D));
      tbl.push_back(v( 1, RS, 1, 0, 0, 0, 0, 0, 1, 1, A, 1, 0, D));
      tbl.push_back(v(15, WT, 0, 0, 0, 0, 0, 0, 1, 1, A, 1, 0, D));
      tbl.push_back(v( 1, ST, 0, 0, 0, 0, 0, 0, 1, 1, A, 1, 0, D));
      tbl.push_back(v(14, ST, 0, 0, 0, 0, 0, 0, 1, 1, A, 0, 0, D));
      tbl.push_back(v( 1, ST, 0, 0, 0, 0, 0, 0, 1, 1, A, 1, 0, D));
      tbl.push_back(v( 1, ST, 0, 0, 0, 0, 0, 0, 1, 1, A, 1, 0, D));
      tbl.push_back(v( 1, WT, 0, 0, 0, 0, 0, 0, 1, 1, A, 1, 0, D));
      tbl.push_back(v( 1, ST, 0, 0, 0, 0, 0, 0, 1, 1, A, 1, 0, D));
      tbl.push_back(v(31, ST, 0, 0, 0, 0, 0, 0, 1, 1, A, 1, 0, D));
      // lock loss, then timeout chain with a request held during WAIT_LOCK
      tbl.push_back(v( 1, RD, 0, 1, 0, 0, 0, 0, 1, 1, A, 0, 0, D));
      tbl.push_back(v( 5, RD, 0, 1, 0, 0, 0, 0, 1, 1, A, 0, 0, D));
      tbl.push_back(v( 1, RS, 1, 0, 0, 0, 1, 1, 1, 1, A, 0, 0, D));
      tbl.push_back(v(15, RS, 1, 0, 0, 0, 0, 1, 1, 2, A, 0, 0, D));
      tbl.push_back(v( 1, WT, 0, 0, 0, 0, 0, 1, 1, 2, A, 0, 1, B));
      tbl.push_back(v(99, WT, 0, 0, 0, 0, 0, 1, 1, 2, A, 0, 1, B));
      tbl.push_back(v( 1, RS, 1, 0, 0, 0, 0, 2, 1, 2, A, 0, 1, B));
      tbl.push_back(v(15, RS, 1, 0, 0, 0, 0, 2, 1, 2, A, 0, 1, B));
      tbl.push_back(v( 1, WT, 0, 0, 0, 0, 0, 2, 1, 2, A, 0, 1, B));
      tbl.push_back(v(99, WT, 0, 0, 0, 0, 0, 2, 1, 2, A, 0, 0, D));
      tbl.push_back(v( 1, RS, 1, 0, 0, 0, 0, 3, 1, 2, A, 0, 0, D));
      tbl.push_back(v(15, RS, 1, 0, 0, 0, 0, 3, 1, 2, A, 0, 0, D));
      tbl.push_back(v( 1, WT, 0, 0, 0, 0, 0, 3, 1, 2, A, 0, 0, D));
      tbl.push_back(v(99, WT, 0, 0, 0, 0, 0, 3, 1, 2, A, 0, 0, D));
      tbl.push_back(v( 1, FL, 1, 0, 1, 0, 0, 3, 1, 2, A, 0, 0, D));
      tbl.push_back(v(20, FL, 1, 0, 1, 0, 0, 3, 1, 2, A, 0, 1, B));
      // recovery from FAIL through reconfig
      tbl.push_back(v( 1, RS, 1, 0, 0, 1, 0, 0, 1, 2, B, 1, 0, D));
      tbl.push_back(v( 1, RS, 1, 0, 0, 0, 0, 0, 2, 2, B, 1, 0, D));
      tbl.push_back(v(14, RS, 1, 0, 0, 0, 0, 0, 2, 2, B, 1, 0, D));
      tbl.push_back(v( 1, WT, 0, 0, 0, 0, 0, 0, 2, 2, B, 1, 0, D));
      tbl.push_back(v( 1, ST, 0, 0, 0, 0, 0, 0, 2, 2, B, 1, 0, D));
      tbl.push_back(v(31, ST, 0, 0, 0, 0, 0, 0, 2, 2, B, 1, 0, D));
      tbl.push_back(v( 1, RD, 0, 1, 0, 0, 0, 0, 2, 2, B, 1, 0, D));

      step(3);
      check_all("in_reset", v(0, RS, 1, 0, 0, 0, 0, 0, 0, 0, D, 0, 0, D));
      reset_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].adv);
         check_all($sformatf("row%0d", i), tbl[i]);
         pll_lock = tbl[i].lock;
         cfg_req  = tbl[i].req;
         {cfg_idsel, cfg_fbdsel, cfg_odsel} = tbl[i].csel;
      end

      // mid-run reset in READY: asynchronous return to reset values
      reset_n = 1'b0;
      #1;
      check_all("async_reset", v(0, RS, 1, 0, 0, 0, 0, 0, 2, 2, D, 1, 0, D));
      step(2);
      check_all("held_reset", v(0, RS, 1, 0, 0, 0, 0, 0, 2, 2, D, 1, 0, D));
      reset_n = 1'b1;
      n = 0;
      while (clk_ready !== 1'b1 && n < 200) begin
         step(1);
         n++;
      end
      chk("ready_latency", n, RC + 1 + LS);
      check_all("relock", v(0, RD, 0, 1, 0, 0, 0, 0, 2, 2, D, 1, 0, D));

      // reconfig in the same cycle as a filtered lock loss
      pll_lock = 1'b0;
      step(LF + 1);
      check_all("pre_race", v(0, RD, 0, 1, 0, 0, 0, 0, 2, 2, D, 0, 0, D));
      cfg_req = 1'b1;
      {cfg_idsel, cfg_fbdsel, cfg_odsel} = A;
      step(1);
      check_all("race", v(0, RS, 1, 0, 0, 1, 1, 0, 2, 2, A, 0, 0, D));
      cfg_req = 1'b0;
      step(1);
      check_all("post_race", v(0, RS, 1, 0, 0, 0, 0, 0, 3, 3, A, 0, 0, D));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_sequencer.md
Name: pll_sequencer

Overview:
- Sequences the rPLL that generates the fast system clock from the 27 MHz board clock.
  - Drives the PLL resets.
  - Qualifies LOCK and produces a clean clocks-ready indication.
  - Applies dynamic divider settings (IDSEL/FBDSEL/ODSEL) on request.
- Runs entirely in the 27 MHz input-clock domain.
- On lock timeout or lock loss it retries a bounded number of times, then reports failure.

Parameters:
- RESET_CYCLES, 16: cycles pll_reset is held high per reset attempt (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synced-lock-high cycles required before ready.
- LOCK_TIMEOUT_CYCLES, 65536: max cycles waiting for lock per attempt.
- LOSS_FILTER, 4: consecutive synced-lock-low cycles in READY that count as lock loss.
- MAX_RETRIES, 3: reset attempts allowed after the first before FAIL.
- DEF_IDSEL, 6'd57: reset value of pll_idsel (PLL-native encoding).
- DEF_FBDSEL, 6'd12: reset value of pll_fbdsel.
- DEF_ODSEL, 6'd62: reset value of pll_odsel.

Ports:
- clkin, in, 1: 27 MHz reference clock.
- reset_n, in, 1: asynchronous active-low reset.
- pll_lock, in, 1: rPLL LOCK, asynchronous to clkin.
- pll_reset, out, 1: to rPLL RESET.
- pll_reset_p, out, 1: to rPLL RESET_P; always equal to pll_reset.
- pll_idsel, out, 6: to rPLL IDSEL.
- pll_fbdsel, out, 6: to rPLL FBDSEL.
- pll_odsel, out, 6: to rPLL ODSEL.
- cfg_req, in, 1: reconfigure request; held by requester until cfg_ack.
- cfg_idsel, in, 6: requested IDSEL; valid while cfg_req=1.
- cfg_fbdsel, in, 6: requested FBDSEL; valid while cfg_req=1.
- cfg_odsel, in, 6: requested ODSEL; valid while cfg_req=1.
- cfg_ack, out, 1: one-cycle pulse when the request is captured.
- clk_ready, out, 1: PLL locked and stable. Consumers in the PLL domain must resynchronise it.
- lock_lost, out, 1: one-cycle pulse on a filtered lock loss in READY.
- fail, out, 1: retries exhausted; sticky until reconfig or reset.
- retry_count, out, 2: attempts used since last successful start or reconfig.

Behaviour:
- Reset values (reset_n=0, asynchronous):
  - State = S_RESET with counter = 0.
  - pll_reset = 1, pll_reset_p = 1.
  - Selects = DEF_* values.
  - clk_ready = 0, cfg_ack = 0, lock_lost = 0, fail = 0, retry_count = 0.
  - Synchronizer flops = 0.
- pll_lock passes through a 2-flop synchronizer; lock_s is its output, giving 2 cycles latency. Only lock_s is used.
- One shared counter, width $clog2(max parameter + 1), cleared on every state entry.
- S_RESET:
  - pll_reset = 1 for exactly RESET_CYCLES cycles, then go to S_WAIT_LOCK.
- S_WAIT_LOCK (pll_reset = 0):
  - lock_s = 1: go to S_STABLE.
  - Counter reaches LOCK_TIMEOUT_CYCLES-1: take the RETRY action.
- S_STABLE:
  - lock_s = 0: return to S_WAIT_LOCK (timeout restarts).
  - Otherwise, after LOCK_STABLE_CYCLES consecutive lock_s = 1 cycles, go to S_READY.
  - Timing: if lock_s is first high at cycle t, clk_ready = 1 from cycle t+1+LOCK_STABLE_CYCLES. retry_count clears to 0 on entering S_READY.
- S_READY:
  - clk_ready = 1.
  - LOSS_FILTER consecutive lock_s = 0 cycles: lock_lost pulses, clk_ready drops on the same edge, take the RETRY action.
  - A lock_s low run shorter than LOSS_FILTER is ignored and resets the filter count.
- RETRY action:
  - retry_count < MAX_RETRIES: retry_count++, go to S_RESET.
  - Otherwise go to S_FAIL.
- S_FAIL:
  - pll_reset = 1 and fail = 1, held.
  - Leaves only on cfg_req or reset_n.
- Reconfiguration:
  - cfg_req is accepted only in S_READY or S_FAIL; it is ignored (not queued) in other states.
  - On acceptance:
    - cfg_* are latched into pll_*sel.
    - cfg_ack pulses the next cycle.
    - fail, clk_ready and retry_count clear.
    - State goes to S_RESET, so the PLL is always reset around a divider change.
  - cfg_req in the same cycle as a filtered lock loss: reconfig wins and lock_lost still pulses, but retry_count does not increment.
- reset_n asserted mid-operation returns to reset values immediately; the selects revert to DEF_*.

Test Plan:
- Cold start: release reset_n, raise pll_lock at cycle 40 → pll_reset high for cycles 0..15; clk_ready rises at cycle 40+2+1+1024 (±1 for the sync edge); retry_count = 0.
- Timeout chain: pll_lock held 0 → 4 reset pulses of 16 cycles, each separated by 65536 wait cycles; retry_count = 1, 2, 3; then fail = 1 and pll_reset stays high.
- Lock-loss filter:
  - In READY, drop pll_lock for 3 cycles → no lock_lost, clk_ready stays 1.
  - Drop for 6 cycles → single lock_lost pulse, clk_ready = 0, retry_count = 1, new 16-cycle reset.
- Stability restart: in STABLE at count 500, pulse pll_lock low 1 cycle → state returns to WAIT_LOCK; clk_ready delayed by a full 1024 after relock.
- Reconfig:
  - In READY, cfg_req with idsel = 6'd58, fbdsel = 6'd20, odsel = 6'd60 → cfg_ack one cycle later, outputs updated, clk_ready = 0, 16-cycle reset, relock.
  - The same request during WAIT_LOCK → no ack until READY.
- Recovery from FAIL and mid-run reset:
  - cfg_req in FAIL → fail clears, retry_count = 0, sequence restarts.
  - reset_n pulsed low in READY → all outputs back to reset values and selects = DEF_*.
